// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - ROM request, redirect and instruction stream bundle of the fetch queue
interface instr_fetch_queue_if #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             rom_en;
  logic [WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0] rom_instr;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             instr_valid;
  logic [WIDTH-1:0] instr_out;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_ready;
  logic [CW-1:0]    count;

  // master is the fetch queue itself; slave is the ROM plus the core
  modport master (
    output rom_en, rom_addr, instr_valid, instr_out, instr_pc, count,
    input  rom_instr, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  rom_en, rom_addr, instr_valid, instr_out, instr_pc, count,
    output rom_instr, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - prefetch queue between instruction ROM and core fetch/decode
module instr_fetch_queue #(
  parameter int unsigned      WIDTH    = 48,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_queue_if.master  bus
);
  localparam int unsigned   PW   = $clog2(DEPTH);
  localparam int unsigned   CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_pc;
  logic             inflight;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] hold_instr;
  logic [WIDTH-1:0] hold_pc;

  logic [CW-1:0]    credit_used;
  logic             rom_en;
  logic             head_valid;
  logic             push;
  logic             pop;

  // A request reserves a slot until its response lands; a same-cycle pop frees nothing yet
  assign credit_used = count + CW'(inflight);
  assign rom_en      = rst_n && !bus.redirect && (credit_used < FULL);
  assign head_valid  = (count != '0);
  assign pop         = head_valid && bus.instr_ready;
  assign push        = inflight && !bus.redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      req_pc     <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      // Remember what was last shown so the outputs stay put once the queue drains or flushes
      if (head_valid) begin
        hold_instr <= instr_mem[rd_ptr];
        hold_pc    <= pc_mem[rd_ptr];
      end
      inflight <= rom_en;
      if (rom_en) begin
        fetch_pc <= fetch_pc + PC_STEP;
        req_pc   <= fetch_pc;
      end
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.rom_instr;
      pc_mem[wr_ptr]    <= req_pc;
    end
  end

  assign bus.rom_en      = rom_en;
  assign bus.rom_addr    = fetch_pc;
  assign bus.instr_valid = head_valid;
  assign bus.instr_out   = head_valid ? instr_mem[rd_ptr] : hold_instr;
  assign bus.instr_pc    = head_valid ? pc_mem[rd_ptr]    : hold_pc;
  assign bus.count       = count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == FULL));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
  localparam int unsigned WIDTH = 48;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] pc_log  [$];
  logic [WIDTH-1:0] ins_log [$];

  always #5 clk = ~clk;

  instr_fetch_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  instr_fetch_queue #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PC_STEP(48'd1), .RESET_PC(48'd0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ROM: word n = 0xA000 + n, one cycle after the request
  always @(posedge clk) if (bus.rom_en) bus.rom_instr <= 48'hA000 + bus.rom_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    #1;
    if (bus.instr_valid && bus.instr_ready) begin
      pc_log.push_back(bus.instr_pc);
      ins_log.push_back(bus.instr_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    pc_log.delete();
    ins_log.delete();
  endtask

  task automatic check_range(input string tag, input int first, input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_pc%0d", tag, i), pc_log[first+i], base + WIDTH'(i));
      check($sformatf("%s_ins%0d", tag, i), ins_log[first+i], 48'hA000 + base + WIDTH'(i));
    end
  endtask

  task automatic restart;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    #3;
    check("rst_rom_en", bus.rom_en, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_count", bus.count, 0);
    check("rst_instr_out", bus.instr_out, 0);
    check("rst_instr_pc", bus.instr_pc, 0);

    // 1: streaming with ready high
    bus.instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    #1;
    check("t1_rom_en_c0", bus.rom_en, 1);
    check("t1_rom_addr_c0", bus.rom_addr, 0);
    check("t1_valid_c0", bus.instr_valid, 0);
    tick();
    check("t1_valid_c1", bus.instr_valid, 0);
    tick();
    check("t1_valid_c2", bus.instr_valid, 1);
    check("t1_pc_c2", bus.instr_pc, 0);
    check("t1_ins_c2", bus.instr_out, 48'hA000);
    repeat (8) tick();
    check("t1_log_size", pc_log.size(), 8);
    check_range("t1", 0, 8, 48'd0);
    check("t1_steady_count", bus.count, 1);
    check("t1_rom_addr_c10", bus.rom_addr, 10);

    // 2: stall from start until full, then drain in order
    bus.instr_ready = 1'b0;
    restart();
    repeat (6) tick();
    check("t2_count_full", bus.count, 4);
    check("t2_rom_en_full", bus.rom_en, 0);
    check("t2_rom_addr_full", bus.rom_addr, 4);
    check("t2_head_pc", bus.instr_pc, 0);
    bus.instr_ready = 1'b1;
    repeat (10) tick();
    check("t2_log_size", pc_log.size(), 10);
    check_range("t2", 0, 10, 48'd0);

    // 3: redirect while full
    bus.instr_ready = 1'b0;
    repeat (6) tick();
    check("t3_count_full", bus.count, 4);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 48'h40;
    #1;
    check("t3_rom_en_redirect", bus.rom_en, 0);
    tick();
    bus.redirect = 1'b0;
    #1;
    check("t3_count_flushed", bus.count, 0);
    check("t3_valid_flushed", bus.instr_valid, 0);
    check("t3_rom_en_after", bus.rom_en, 1);
    check("t3_rom_addr_after", bus.rom_addr, 48'h40);
    check("t3_hold_pc", bus.instr_pc, 10);
    check("t3_hold_ins", bus.instr_out, 48'hA00A);
    bus.instr_ready = 1'b1;
    tick();
    tick();
    check("t3_first_valid", bus.instr_valid, 1);
    check("t3_first_pc", bus.instr_pc, 48'h40);
    check("t3_first_ins", bus.instr_out, 48'hA040);

    // 4: redirect while a response is in flight
    restart();
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 48'h80;
    tick();
    bus.redirect = 1'b0;
    repeat (5) tick();
    check("t4_log_size", pc_log.size(), 3);
    check_range("t4", 0, 3, 48'h80);

    // 5: redirect coinciding with the handshake of PC 5
    restart();
    repeat (7) tick();
    check("t5_head_valid", bus.instr_valid, 1);
    check("t5_head_pc", bus.instr_pc, 5);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 48'h100;
    tick();
    bus.redirect = 1'b0;
    check("t5_valid_flushed", bus.instr_valid, 0);
    check("t5_hold_pc", bus.instr_pc, 5);
    check("t5_hold_ins", bus.instr_out, 48'hA005);
    repeat (8) tick();
    check("t5_log_size", pc_log.size(), 12);
    check_range("t5_old", 0, 6, 48'd0);
    check_range("t5_new", 6, 6, 48'h100);

    // 6: asynchronous reset mid-stream
    check("t6_valid_before", bus.instr_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rom_en_rst", bus.rom_en, 0);
    check("t6_valid_rst", bus.instr_valid, 0);
    check("t6_count_rst", bus.count, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    #1;
    check("t6_rom_en_c0", bus.rom_en, 1);
    check("t6_rom_addr_c0", bus.rom_addr, 0);
    tick();
    check("t6_valid_c1", bus.instr_valid, 0);
    tick();
    check("t6_valid_c2", bus.instr_valid, 1);
    check("t6_pc_c2", bus.instr_pc, 0);
    check("t6_ins_c2", bus.instr_out, 48'hA000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
